seq_multibit_adder: RTL and testbench

Parametrised multi-cycle adder/subtractor, successor to the combinational multibit adder. Processes operands CHUNK bits per clock, ripple-carrying between chunks in a register. Valid/ready handshakes on input and output let it sit between registered pipeline stages. Reports carry and signed overflow. Trades latency for a short carry chain at wide WIDTH.

---
 rtl/seq_multibit_adder_pkg.sv | 22 ++
 rtl/seq_multibit_adder_chunk_adder.sv | 28 ++
 rtl/seq_multibit_adder.sv | 197 +++++++++++++++++++
 tb/tb_seq_multibit_adder.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_multibit_adder_pkg.sv
// -----------------------------------------------------------------------------
// seq_multibit_adder_pkg
// Shared definitions for the sequential multi-bit adder/subtractor:
//   - state_t      : FSM state encoding (IDLE / ADD / DONE)
//   - chunk_cfg_ok : elaboration-time legality check for the WIDTH/CHUNK pair
// No ports (package).
// -----------------------------------------------------------------------------
package seq_multibit_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A configuration is legal when WIDTH is a positive whole multiple of CHUNK.
  function automatic bit chunk_cfg_ok(input int width, input int chunk);
    return (width >= 1) && (chunk >= 1) && (chunk <= width) &&
           ((width % chunk) == 0);
  endfunction

endpackage : seq_multibit_adder_pkg

// File: rtl/seq_multibit_adder_chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Combinational CHUNK-bit adder slice with carry-in and carry-out. The
// sequential adder reuses one instance for every chunk of the operands.
// Ports:
//   a, b  [CHUNK-1:0]  operand slices
//   cin                carry into the slice
//   sum   [CHUNK-1:0]  slice sum
//   cout               carry out of the slice
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK:0] total;

  // Zero-extend everything to CHUNK+1 bits so the top bit is the carry out.
  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum   = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

endmodule : chunk_adder

// File: rtl/seq_multibit_adder.sv
// -----------------------------------------------------------------------------
// seq_multibit_adder
// Multi-cycle adder/subtractor. Operands are latched on accept and summed
// CHUNK bits per clock through a single chunk_adder, with the inter-chunk
// carry held in a register. Result, carry and signed overflow are presented
// with a valid/ready handshake and held until consumed.
//
// Optional build macro:
//   SEQ_ADDER_SATURATE_EN - on signed overflow, clamp out to the signed
//                           extreme in the direction of operand A's sign.
//                           carry/overflow flags are unaffected.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   in_valid   operands and mode presented
//   in_ready   block can accept an operation (IDLE only)
//   a, b       [WIDTH-1:0] operands
//   sub        0 = a+b, 1 = a-b
//   out_valid  result valid, held until out_ready
//   out_ready  downstream accepts result
//   out        [WIDTH-1:0] sum/difference
//   carry      final carry out (for subtract, 1 = no borrow)
//   overflow   signed overflow of the WIDTH-bit result
// -----------------------------------------------------------------------------
module seq_multibit_adder
  import seq_multibit_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow
);

  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_multibit_adder: WIDTH (%0d) must be a positive multiple of CHUNK (%0d)",
           WIDTH, CHUNK);
  end

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_q, b_q;       // A and B' (B already inverted for subtract)
  logic [WIDTH-1:0] result_q;       // partial result, filled one chunk per cycle
  logic             carry_q;        // ripple carry between chunks
  logic [WIDTH-1:0] out_q;
  logic             carry_out_q;
  logic             overflow_q;

  logic             accept;
  logic             last_chunk;
  int               chunk_lsb;
  logic [CHUNK-1:0] a_chunk, b_chunk, sum_chunk;
  logic             chunk_cout;
  logic [WIDTH-1:0] result_full;
  logic [WIDTH-1:0] out_final;
  logic             ovf_final;

  assign accept     = (state_q == ST_IDLE) && in_valid;
  assign last_chunk = (count_q == LAST_CNT);
  assign chunk_lsb  = int'(count_q) * CHUNK;

  // ---------------------------------------------------------------------------
  // Chunk datapath: one adder slice, operand slices selected by count
  // ---------------------------------------------------------------------------
  assign a_chunk = a_q[chunk_lsb +: CHUNK];
  assign b_chunk = b_q[chunk_lsb +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .sum  (sum_chunk),
    .cout (chunk_cout)
  );

`ifdef SEQ_ADDER_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {WIDTH{1'b1}} >> 1;  // 0111..1
  localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;            // 1000..0
`endif

  // Result as it will look once the current chunk is written; on the final
  // ADD edge this is the complete sum, so flags are derived from it directly.
  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    result_full                     = result_q;
    result_full[chunk_lsb +: CHUNK] = sum_chunk;
    ovf_final = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                (result_full[WIDTH-1] != a_q[WIDTH-1]);
    out_final = result_full;
`ifdef SEQ_ADDER_SATURATE_EN
    if (ovf_final) begin
      out_final = a_q[WIDTH-1] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (in_valid)   state_d = ST_ADD;
      ST_ADD:  if (last_chunk) state_d = ST_DONE;
      ST_DONE: if (out_ready)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // FSM: handshake outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and result registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      carry_q     <= 1'b0;
      out_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else if (accept) begin
      count_q <= '0;
      carry_q <= sub;   // +1 of the two's-complement negate enters as carry-in
    end else if (state_q == ST_ADD) begin
      count_q <= count_q + 1'b1;
      carry_q <= chunk_cout;
      if (last_chunk) begin
        out_q       <= out_final;
        carry_out_q <= chunk_cout;
        overflow_q  <= ovf_final;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and partial-result registers
  // ---------------------------------------------------------------------------
  // NOTE: these datapath registers are deliberately not reset: each one is
  // fully rewritten (operands on accept, every result chunk during ADD)
  // before anything downstream observes it.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end
    if (state_q == ST_ADD) begin
      result_q <= result_full;
    end
  end

  assign out      = out_q;
  assign carry    = carry_out_q;
  assign overflow = overflow_q;

endmodule : seq_multibit_adder

// File: tb/tb_seq_multibit_adder.sv
// -----------------------------------------------------------------------------
// tb_seq_multibit_adder
// Directed self-checking bench for seq_multibit_adder at WIDTH=8, CHUNK=2.
// Expected results are hand-computed; SEQ_ADDER_SATURATE_EN selects the
// clamped expectations for overflowing vectors.
// -----------------------------------------------------------------------------
module tb_seq_multibit_adder;

  localparam int WIDTH      = 8;
  localparam int CHUNK      = 2;
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int TIMEOUT    = 20;

`ifdef SEQ_ADDER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] e_out;
    logic       e_c;
    logic       e_v;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       carry;
  logic       overflow;

  int         vectors     = 0;
  int         miscompares = 0;

  // Observations from the most recent operation
  int         lat;
  logic [7:0] got_out;
  logic       got_c, got_v;

  always #5 clk = ~clk;

  seq_multibit_adder #(
    .WIDTH (WIDTH),
    .CHUNK (CHUNK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .overflow  (overflow)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for in_ready, present one operation and let it be accepted.
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    int waited = 0;
    while (!in_ready && waited < TIMEOUT) begin
      tick();
      waited++;
    end
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept until out_valid; lat = -1 on timeout.
  task automatic wait_done();
    lat = 0;
    while (!out_valid && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    got_out = out; got_c = carry; got_v = overflow;
  endtask

  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input logic sv);
    start_op(av, bv, sv);
    wait_done();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; sub = 1'b0;
    tick();
    tick();
    vectors++;
    if ({in_ready, out_valid, out, carry, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_state: got in_ready=%b out_valid=%b out=%h c=%b v=%b, expected 1 0 00 0 0",
               in_ready, out_valid, out, carry, overflow);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    vec_t v[4];
    v = '{'{8'h00, 8'h01, 1'b0, 8'h01,                  1'b0, 1'b0},
          '{8'hFF, 8'h01, 1'b0, 8'h00,                  1'b1, 1'b0},
          '{8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80,    1'b0, 1'b1},
          '{8'h80, 8'h80, 1'b0, SAT ? 8'h80 : 8'h00,    1'b1, 1'b1}};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, v[i].s);
      vectors++;
      if (lat !== NUM_CHUNKS) begin
        miscompares++;
        $display("FAIL add_latency[%0d]: got %0d edges, expected %0d", i, lat, NUM_CHUNKS);
      end
      vectors++;
      if ({got_out, got_c, got_v} !== {v[i].e_out, v[i].e_c, v[i].e_v}) begin
        miscompares++;
        $display("FAIL add[%0d] a=%h b=%h: got out=%h c=%b v=%b, expected out=%h c=%b v=%b",
                 i, v[i].a, v[i].b, got_out, got_c, got_v, v[i].e_out, v[i].e_c, v[i].e_v);
      end
      tick();  // consumed with out_ready=1
      vectors++;
      if ({out_valid, in_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL add_consume[%0d]: got out_valid=%b in_ready=%b, expected 0 1",
                 i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_sub();
    vec_t v[4];
    v = '{'{8'h05, 8'h07, 1'b1, 8'hFE,                  1'b0, 1'b0},
          '{8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F,    1'b1, 1'b1},
          '{8'h55, 8'h55, 1'b1, 8'h00,                  1'b1, 1'b0},
          '{8'h00, 8'h01, 1'b1, 8'hFF,                  1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, v[i].s);
      vectors++;
      if (lat !== NUM_CHUNKS) begin
        miscompares++;
        $display("FAIL sub_latency[%0d]: got %0d edges, expected %0d", i, lat, NUM_CHUNKS);
      end
      vectors++;
      if ({got_out, got_c, got_v} !== {v[i].e_out, v[i].e_c, v[i].e_v}) begin
        miscompares++;
        $display("FAIL sub[%0d] a=%h b=%h: got out=%h c=%b v=%b, expected out=%h c=%b v=%b",
                 i, v[i].a, v[i].b, got_out, got_c, got_v, v[i].e_out, v[i].e_c, v[i].e_v);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e_out;
    e_out = SAT ? 8'h7F : 8'h80;   // 0x40 + 0x40 overflows positive
    out_ready = 1'b0;
    do_op(8'h40, 8'h40, 1'b0);
    vectors++;
    if (lat !== NUM_CHUNKS) begin
      miscompares++;
      $display("FAIL bp_latency: got %0d edges, expected %0d", lat, NUM_CHUNKS);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({out_valid, in_ready, out, carry, overflow} !== {1'b1, 1'b0, e_out, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got out_valid=%b in_ready=%b out=%h c=%b v=%b, expected 1 0 %h 0 1",
                 i, out_valid, in_ready, out, carry, overflow, e_out);
      end
    end
    out_ready = 1'b1;
    tick();
    vectors++;
    if ({out_valid, in_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_inputs();
    start_op(8'h12, 8'h34, 1'b0);
    // Upset every input while the operation is in flight.
    a = 8'hFF; b = 8'hFF; sub = 1'b1; in_valid = 1'b1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_in_ready: got %b, expected 0", in_ready);
    end
    wait_done();
    in_valid = 1'b0;
    vectors++;
    if ({lat, got_out, got_c, got_v} !== {NUM_CHUNKS, 8'h46, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL busy_result: got lat=%0d out=%h c=%b v=%b, expected lat=%0d out=46 c=0 v=0",
               lat, got_out, got_c, got_v, NUM_CHUNKS);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int second = -1;
    a = 8'h01; b = 8'h02; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (out_valid) begin
        if (first < 0) first = t;
        else if (second < 0) begin
          second = t;
          in_valid = 1'b0;
          vectors++;
          if (out !== 8'h03) begin
            miscompares++;
            $display("FAIL b2b_result: got %h, expected 03", out);
          end
        end
      end
    end
    in_valid = 1'b0;
    vectors++;
    if ((first < 0) || (second < 0) || (second - first != NUM_CHUNKS + 2)) begin
      miscompares++;
      $display("FAIL b2b_spacing: got first=%0d second=%0d, expected spacing %0d",
               first, second, NUM_CHUNKS + 2);
    end
  endtask

  task automatic test_reset_mid_add();
    start_op(8'hAA, 8'h11, 1'b0);   // now in ADD, first chunk pending
    tick();                          // first chunk done; second ADD cycle
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out, carry, overflow} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_add: got in_ready=%b out_valid=%b out=%h c=%b v=%b, expected 1 0 00 0 0",
               in_ready, out_valid, out, carry, overflow);
    end
    do_op(8'h03, 8'h04, 1'b0);
    vectors++;
    if ({lat, got_out, got_c, got_v} !== {NUM_CHUNKS, 8'h07, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL after_reset_op: got lat=%0d out=%h c=%b v=%b, expected lat=%0d out=07 c=0 v=0",
               lat, got_out, got_c, got_v, NUM_CHUNKS);
    end
    tick();
  endtask

  task automatic test_reset_with_valid();
    int seen = 0;
    a = 8'h01; b = 8'h01; sub = 1'b0;
    reset = 1'b1; in_valid = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_vs_valid: got in_ready=%b, expected 1", in_ready);
    end
    for (int i = 0; i < NUM_CHUNKS + 2; i++) begin
      tick();
      if (out_valid) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_vs_valid_no_result: got %0d valid cycles, expected 0", seen);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_busy_inputs();
    test_back_to_back();
    test_reset_mid_add();
    test_reset_with_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_seq_multibit_adder
